// File: rtl/raster_counter_pkg.sv
// Shared rendering constants and raster sweep state encoding.
package raster_counter_pkg;
  localparam int RC_X_BITS    = 9;   // 320 columns
  localparam int RC_Y_BITS    = 8;   // 240 rows
  localparam int RC_ADDR_BITS = 17;  // 320*240 pixels

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;
endpackage

// File: rtl/raster_counter_if.sv
// Request/beat bundle between a raster sweep client and the counter.
interface raster_counter_if
  import raster_counter_pkg::*;
#(
  parameter int X_BITS    = RC_X_BITS,
  parameter int Y_BITS    = RC_Y_BITS,
  parameter int ADDR_BITS = RC_ADDR_BITS
) ();
  logic                 start;
  logic                 abort;
  logic [X_BITS-1:0]    width;
  logic [Y_BITS-1:0]    height;
  logic [ADDR_BITS-1:0] base;
  logic [ADDR_BITS-1:0] pitch;
  logic                 ready;
  logic                 busy;
  logic                 valid;
  logic [X_BITS-1:0]    x;
  logic [Y_BITS-1:0]    y;
  logic [ADDR_BITS-1:0] addr;
  logic                 last;
  logic                 done;

  modport master (
    output start, abort, width, height, base, pitch, ready,
    input  busy, valid, x, y, addr, last, done
  );
  modport slave (
    input  start, abort, width, height, base, pitch, ready,
    output busy, valid, x, y, addr, last, done
  );
endinterface

// File: rtl/raster_counter_axis_counter.sv
// Single-axis up-counter: clear to 0, count on enable, flag at lim-1.
module axis_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] lim,
  output logic [W-1:0] cnt,
  output logic         tc
);
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)  cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en)  cnt <= cnt + W'(1);
  end

  assign tc = (cnt == lim - W'(1));
endmodule

// File: rtl/raster_counter.sv
// Row-major 2D sweep counter emitting (x, y, addr) beats over valid/ready.
module raster_counter
  import raster_counter_pkg::*;
#(
  parameter int X_BITS    = RC_X_BITS,
  parameter int Y_BITS    = RC_Y_BITS,
  parameter int ADDR_BITS = RC_ADDR_BITS
) (
  input  logic            clk,
  input  logic            resetn,
  raster_counter_if.slave bus
);
  state_t               state, state_nxt;
  logic [X_BITS-1:0]    w_lim, x_cnt;
  logic [Y_BITS-1:0]    h_lim, y_cnt;
  logic [ADDR_BITS-1:0] pitch_q, row_base, addr_q;
  logic                 start_acc, accept, x_tc, y_tc, row_wrap, is_last;

  assign start_acc = (state == ST_IDLE) && bus.start && !bus.abort;
  assign accept    = (state == ST_RUN) && bus.ready && !bus.abort;
  assign is_last   = x_tc && y_tc;
  assign row_wrap  = accept && x_tc && !y_tc;

  // x parks on the final column after the last beat so it holds through DONE
  axis_counter #(.W(X_BITS)) u_x (
    .clk, .resetn,
    .clr (start_acc || row_wrap),
    .en  (accept && !x_tc),
    .lim (w_lim),
    .cnt (x_cnt),
    .tc  (x_tc)
  );

  axis_counter #(.W(Y_BITS)) u_y (
    .clk, .resetn,
    .clr (start_acc),
    .en  (row_wrap),
    .lim (h_lim),
    .cnt (y_cnt),
    .tc  (y_tc)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start_acc)
                 state_nxt = (bus.width == '0 || bus.height == '0) ? ST_DONE : ST_RUN;
      ST_RUN:  if (bus.abort || (accept && is_last)) state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      w_lim    <= '0;
      h_lim    <= '0;
      pitch_q  <= '0;
      row_base <= '0;
      addr_q   <= '0;
    end else if (start_acc) begin
      w_lim    <= bus.width;
      h_lim    <= bus.height;
      pitch_q  <= bus.pitch;
      row_base <= bus.base;
      addr_q   <= bus.base;
    end else if (row_wrap) begin
      // incremental row stride keeps multipliers out of the address path
      row_base <= row_base + pitch_q;
      addr_q   <= row_base + pitch_q;
    end else if (accept && !x_tc) begin
      addr_q   <= addr_q + ADDR_BITS'(1);
    end
  end

  assign bus.busy  = (state != ST_IDLE);
  assign bus.valid = (state == ST_RUN);
  assign bus.last  = bus.valid && is_last;
  assign bus.done  = (state == ST_DONE);
  assign bus.x     = x_cnt;
  assign bus.y     = y_cnt;
  assign bus.addr  = addr_q;
endmodule

// File: tb/tb_raster_counter.sv
// Scoreboard bench for raster_counter: expected beats queued at start, popped on accept.
module tb_raster_counter;
  import raster_counter_pkg::*;

  typedef struct packed {
    logic [RC_X_BITS-1:0]    x;
    logic [RC_Y_BITS-1:0]    y;
    logic [RC_ADDR_BITS-1:0] addr;
    logic                    last;
  } beat_t;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  raster_counter_if bus ();
  raster_counter dut (.clk(clk), .resetn(resetn), .bus(bus.slave));

  int    tests = 0, fails = 0;
  int    beats = 0, valid_cycles = 0, busy_cycles = 0, done_cnt = 0;
  beat_t exp_q[$];
  beat_t held, cur, exp_b;
  logic  hold_pending = 1'b0;

  // monitor: compare every accepted beat and check stability across stalls
  always @(negedge clk) begin
    if (resetn) begin
      cur = '{x: bus.x, y: bus.y, addr: bus.addr, last: bus.last};
      if (bus.busy)  busy_cycles++;
      if (bus.done)  done_cnt++;
      if (!bus.valid && bus.last) begin
        tests++; fails++;
        $display("FAIL last_gated: last=1 while valid=0");
      end
      if (bus.valid) begin
        valid_cycles++;
        if (hold_pending) begin
          tests++;
          if (cur !== held) begin
            fails++;
            $display("FAIL hold_stable: got %h required %h", cur, held);
          end
        end
        if (bus.ready && !bus.abort) begin
          beats++;
          hold_pending = 1'b0;
          tests++;
          if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL beat_unexpected: got x=%0d y=%0d addr=%0d, none required",
                     cur.x, cur.y, cur.addr);
          end else begin
            exp_b = exp_q.pop_front();
            if (cur !== exp_b) begin
              fails++;
              $display("FAIL beat: got x=%0d y=%0d addr=%0d last=%0b required x=%0d y=%0d addr=%0d last=%0b",
                       cur.x, cur.y, cur.addr, cur.last, exp_b.x, exp_b.y, exp_b.addr, exp_b.last);
            end
          end
        end else begin
          hold_pending = !bus.abort;
          held = cur;
        end
      end else begin
        hold_pending = 1'b0;
      end
    end else begin
      hold_pending = 1'b0;
    end
  end

  task automatic start_sweep(input int w, input int h, input int b, input int p);
    beat_t e;
    for (int yy = 0; yy < h; yy++)
      for (int xx = 0; xx < w; xx++) begin
        e.x    = RC_X_BITS'(xx);
        e.y    = RC_Y_BITS'(yy);
        e.addr = RC_ADDR_BITS'((longint'(b) + longint'(yy) * p + xx) % 131072);
        e.last = (xx == w - 1) && (yy == h - 1);
        exp_q.push_back(e);
      end
    @(posedge clk); #1;
    beats = 0; valid_cycles = 0; busy_cycles = 0; done_cnt = 0;
    bus.width  = RC_X_BITS'(w);
    bus.height = RC_Y_BITS'(h);
    bus.base   = RC_ADDR_BITS'(b);
    bus.pitch  = RC_ADDR_BITS'(p);
    bus.start  = 1'b1;
    @(posedge clk); #1;
    bus.start  = 1'b0;
  endtask

  // mode 0: ready always high; mode 1: ready pattern 1,0,0. inject: cycle to pulse a stray start.
  task automatic run_sweep(input int mode, input int budget, input int inject,
                           output int cyc, output int first_v);
    cyc = 0; first_v = -1;
    while (1) begin
      bus.ready = (mode == 0) ? 1'b1 : (cyc % 3 == 0);
      if (cyc == inject) begin
        bus.start = 1'b1; bus.width = 9'd7; bus.height = 8'd7;
        bus.base = 17'd5; bus.pitch = 17'd9;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      if (bus.valid && first_v < 0) first_v = cyc;
      if (bus.done) break;
      if (cyc >= budget) begin
        tests++; fails++;
        $display("FAIL sweep_timeout: no done after %0d cycles", cyc);
        break;
      end
      @(posedge clk); #1;
      cyc++;
    end
    bus.start = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic check_int(input string name, input int got, input int req);
    tests++;
    if (got !== req) begin
      fails++;
      $display("FAIL %s: got %0d required %0d", name, got, req);
    end
  endtask

  task automatic test_reset();
    int cyc, fv;
    start_sweep(3, 2, 100, 320);
    bus.ready = 1'b1;
    @(posedge clk); @(posedge clk); #2;
    resetn = 1'b0;
    #1;
    tests++;
    if ({bus.busy, bus.valid, bus.last, bus.done} !== 4'b0 ||
        bus.x !== '0 || bus.y !== '0 || bus.addr !== '0) begin
      fails++;
      $display("FAIL async_reset: busy=%0b valid=%0b last=%0b done=%0b x=%0d y=%0d addr=%0d required all 0",
               bus.busy, bus.valid, bus.last, bus.done, bus.x, bus.y, bus.addr);
    end
    exp_q.delete();
    @(posedge clk); #1;
    resetn = 1'b1;
    start_sweep(3, 2, 100, 320);
    run_sweep(0, 50, -1, cyc, fv);
    check_int("basic_first_valid", fv, 0);
    check_int("basic_done_cycle", cyc, 6);
    check_int("basic_beats", beats, 6);
    check_int("basic_queue_left", exp_q.size(), 0);
  endtask

  task automatic test_backpressure();
    int cyc, fv;
    start_sweep(3, 2, 100, 320);
    run_sweep(1, 60, -1, cyc, fv);
    check_int("bp_done_cycle", cyc, 16);
    check_int("bp_beats", beats, 6);
    check_int("bp_queue_left", exp_q.size(), 0);
  endtask

  task automatic test_degenerate();
    int cyc, fv;
    start_sweep(0, 5, 7, 3);
    run_sweep(0, 5, -1, cyc, fv);
    check_int("zero_w_done_cycle", cyc, 0);
    check_int("zero_w_valid_cycles", valid_cycles, 0);
    check_int("zero_w_done_pulses", done_cnt, 1);
    start_sweep(1, 1, 42, 3);
    run_sweep(0, 10, -1, cyc, fv);
    check_int("one_px_beats", beats, 1);
    check_int("one_px_queue_left", exp_q.size(), 0);
  endtask

  task automatic test_abort();
    int cyc, fv, ab_cyc;
    logic seen;
    start_sweep(4, 4, 0, 16);
    bus.ready = 1'b1;
    ab_cyc = -1; seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      bus.abort = (beats == 4 && ab_cyc < 0);
      if (bus.abort) ab_cyc = c;
      @(negedge clk);
      if (bus.done) begin
        seen = 1'b1;
        check_int("abort_done_latency", c, ab_cyc + 1);
        break;
      end
      @(posedge clk); #1;
    end
    bus.abort = 1'b0;
    check_int("abort_done_seen", int'(seen), 1);
    @(posedge clk); #1;
    check_int("abort_busy_drop", int'(bus.busy), 0);
    repeat (3) @(posedge clk);
    #1;
    check_int("abort_done_pulses", done_cnt, 1);
    check_int("abort_beats", beats, 4);
    check_int("abort_queue_left", exp_q.size(), 12);
    exp_q.delete();
    start_sweep(2, 2, 10, 100);
    run_sweep(0, 20, -1, cyc, fv);
    check_int("post_abort_beats", beats, 4);
    check_int("post_abort_queue_left", exp_q.size(), 0);
  endtask

  task automatic test_start_busy_wrap();
    int cyc, fv;
    start_sweep(3, 2, 100, 320);
    run_sweep(0, 30, 2, cyc, fv);
    check_int("busy_start_beats", beats, 6);
    check_int("busy_start_queue_left", exp_q.size(), 0);
    check_int("busy_start_final_addr", int'(bus.addr), 422);
    start_sweep(4, 1, 131070, 0);
    run_sweep(0, 20, -1, cyc, fv);
    check_int("wrap_beats", beats, 4);
    check_int("wrap_queue_left", exp_q.size(), 0);
  endtask

  task automatic test_full_frame();
    int cyc, fv;
    start_sweep(320, 240, 0, 320);
    run_sweep(0, 77000, -1, cyc, fv);
    check_int("frame_done_cycle", cyc, 76800);
    check_int("frame_beats", beats, 76800);
    check_int("frame_valid_cycles", valid_cycles, 76800);
    check_int("frame_busy_cycles", busy_cycles, 76801);
    check_int("frame_final_addr", int'(bus.addr), 76799);
    check_int("frame_queue_left", exp_q.size(), 0);
  endtask

  initial begin
    bus.start = 1'b0; bus.abort = 1'b0; bus.ready = 1'b0;
    bus.width = '0; bus.height = '0; bus.base = '0; bus.pitch = '0;
    repeat (2) @(posedge clk);
    #1;
    check_int("reset_busy", int'(bus.busy), 0);
    check_int("reset_addr", int'(bus.addr), 0);
    resetn = 1'b1;
    test_reset();
    test_backpressure();
    test_degenerate();
    test_abort();
    test_start_busy_wrap();
    test_full_frame();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
